// File: rtl/kernel_launcher_if.sv
// Launch request handshake and dispatcher control bundle for kernel_launcher.
// The package carries the launch config type shared by host, launcher and dispatcher.
package kernel_launcher_pkg;
  typedef struct packed {
    logic [15:0] kernel_id;
    logic [15:0] num_blocks;
  } kernel_config_t;
endpackage

interface kernel_launcher_if;
  import kernel_launcher_pkg::*;

  logic           launch_valid;
  logic           launch_ready;
  kernel_config_t launch_config;
  logic           disp_reset;
  logic           disp_start;
  kernel_config_t disp_config;
  logic           disp_done;

  // Host plus dispatcher side of the bundle.
  modport master (
    output launch_valid, launch_config, disp_done,
    input  launch_ready, disp_reset, disp_start, disp_config
  );

  // Launcher side of the bundle.
  modport slave (
    input  launch_valid, launch_config, disp_done,
    output launch_ready, disp_reset, disp_start, disp_config
  );
endinterface

// File: rtl/kernel_launcher.sv
// Launch queue in front of the block dispatcher: buffers requests, runs them one at a time,
// and retires zero-block and hung kernels locally so the dispatcher never stalls.
module kernel_launcher
  import kernel_launcher_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  kernel_launcher_if.slave    bus,
  output logic                kernel_done,
  output logic                kernel_timeout,
  output logic                error_sticky,
  input  logic                err_clear,
  output logic [31:0]         kernels_completed,
  output logic                busy
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [31:0] RST_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_COMPLETE} state_t;

  state_t         state, state_nxt;
  kernel_config_t fifo_mem [QUEUE_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full, push, pop;
  kernel_config_t head;
  logic [31:0]    rst_cnt, run_cnt;
  logic           timeout_hit, to_flag_nxt;

  logic           disp_reset_r, disp_start_r;
  kernel_config_t disp_config_r;
  logic           disp_reset_nxt, disp_start_nxt, kernel_done_nxt, kernel_timeout_nxt;
  logic           error_nxt;
  kernel_config_t disp_config_nxt;
  logic [31:0]    completed_nxt;

  // Extra MSB on the pointers separates full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.launch_valid && !full;
  assign pop   = (state == S_IDLE) && !empty;
  assign head  = fifo_mem[rd_ptr[AW-1:0]];

  assign bus.launch_ready = !full;
  assign bus.disp_reset   = disp_reset_r;
  assign bus.disp_start   = disp_start_r;
  assign bus.disp_config  = disp_config_r;
  assign busy             = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.launch_config;
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (run_cnt == TO_LAST);

  // State register together with the registered outputs and phase counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      rst_cnt           <= '0;
      run_cnt           <= '0;
      disp_reset_r      <= 1'b1;
      disp_start_r      <= 1'b0;
      disp_config_r     <= '0;
      kernel_done       <= 1'b0;
      kernel_timeout    <= 1'b0;
      error_sticky      <= 1'b0;
      kernels_completed <= '0;
    end else begin
      state             <= state_nxt;
      rst_cnt           <= (state == S_RESET) ? rst_cnt + 32'd1 : 32'd0;
      run_cnt           <= (state == S_RUN)   ? run_cnt + 32'd1 : 32'd0;
      disp_reset_r      <= disp_reset_nxt;
      disp_start_r      <= disp_start_nxt;
      disp_config_r     <= disp_config_nxt;
      kernel_done       <= kernel_done_nxt;
      kernel_timeout    <= kernel_timeout_nxt;
      error_sticky      <= error_nxt;
      kernels_completed <= completed_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    to_flag_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) state_nxt = (head.num_blocks == '0) ? S_COMPLETE : S_RESET;
      end
      S_RESET: begin
        if (rst_cnt == RST_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        // A done in the same cycle as the watchdog expiry is a normal completion.
        if (bus.disp_done) begin
          state_nxt = S_COMPLETE;
        end else if (timeout_hit) begin
          state_nxt   = S_COMPLETE;
          to_flag_nxt = 1'b1;
        end
      end
      S_COMPLETE: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they line up with it once registered.
  always_comb begin
    disp_reset_nxt     = (state_nxt != S_RUN);
    disp_start_nxt     = (state_nxt == S_RUN);
    kernel_done_nxt    = (state_nxt == S_COMPLETE);
    kernel_timeout_nxt = to_flag_nxt;
    disp_config_nxt    = pop ? head : disp_config_r;
    completed_nxt      = kernels_completed + 32'(state_nxt == S_COMPLETE);
    error_nxt          = (error_sticky && !err_clear) || to_flag_nxt;
  end

endmodule
